// File: rtl/noc_pe_pkg.sv
// noc_pe_pkg: shared definitions for the traffic-generating processing
// element and for any monitor or router-side block that decodes its flits.
//   - pe_state_e : injection FSM state encoding
//   - width helpers : VC / flit / credit widths
//   - field helpers : bit positions inside {valid, tail, dest, vc, data}
package noc_pe_pkg;

  typedef enum logic [1:0] {
    PE_IDLE = 2'd0,
    PE_SEND = 2'd1,
    PE_DONE = 2'd2
  } pe_state_e;

  // Low bits of the flit payload carry the flit index within the packet.
  localparam int FLIT_IDX_FIELD_W = 8;

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int vc_bits(input int num_vcs);
    return max1($clog2(num_vcs));
  endfunction

  function automatic int flit_w(input int dest_bits, input int vcb, input int dw);
    return 2 + dest_bits + vcb + dw;
  endfunction

  function automatic int cred_w(input int vcb);
    return 1 + vcb;
  endfunction

  // LSB position of the vc field (data occupies [dw-1:0]).
  function automatic int fld_vc_lsb(input int dw);
    return dw;
  endfunction

  function automatic int fld_dest_lsb(input int vcb, input int dw);
    return dw + vcb;
  endfunction

  function automatic int fld_tail(input int dest_bits, input int vcb, input int dw);
    return dw + vcb + dest_bits;
  endfunction

  function automatic int fld_valid(input int dest_bits, input int vcb, input int dw);
    return dw + vcb + dest_bits + 1;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// noc_credit_counter: credit tracker for one virtual channel.
//   clk, rst_n   : clock, asynchronous active-low reset (count -> BUF_DEPTH)
//   en           : synchronous enable, 0 freezes the count
//   i_dec        : a flit is being sent on this VC
//   i_inc        : a credit is being returned on this VC
//   o_avail      : count > 0
//   o_overflow   : returned credit would exceed BUF_DEPTH (count saturates)
module noc_credit_counter
  import noc_pe_pkg::*;
#(
  parameter int BUF_DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic i_dec,
  input  logic i_inc,
  output logic o_avail,
  output logic o_overflow
);

  localparam int CNT_W = max1($clog2(BUF_DEPTH + 1));
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= FULL;
    end else if (en) begin
      if (i_inc && !i_dec && (r_count != FULL)) begin
        r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign o_avail    = (r_count != '0);
  assign o_overflow = en && i_inc && !i_dec && (r_count == FULL);

endmodule

// File: rtl/noc_traffic_pe.sv
// noc_traffic_pe: NoC traffic generator / sink endpoint.
// Injects NUM_PKTS packets of PKT_LEN flits, one start attempt every
// INJ_PERIOD cycles, round-robin over VCs, under credit flow control; sinks
// received flits and returns one credit per flit one cycle later.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : synchronous enable; 0 freezes state, drives outputs to 0
//   dest_cfg     : destination, sampled at packet start
//   flit_out     : {valid, tail, dest, vc, data}, registered
//   flit_in      : received flit, same layout
//   credit_in    : {valid, vc} credit from router
//   credit_out   : {valid, vc} credit to router, registered
//   tx_count     : flits sent;  rx_count : flits received
//   done         : all packets sent;  err_credit : sticky credit overflow
module noc_traffic_pe
  import noc_pe_pkg::*;
#(
  parameter  int NUM_VCS         = 2,
  parameter  int FLIT_DATA_WIDTH = 64,
  parameter  int NUM_RECV_PORTS  = 16,
  parameter  int BUF_DEPTH       = 8,
  parameter  int PKT_LEN         = 4,
  parameter  int INJ_PERIOD      = 10,
  parameter  int NUM_PKTS        = 13,
  localparam int DEST_BITS       = $clog2(NUM_RECV_PORTS),
  localparam int VC_BITS         = vc_bits(NUM_VCS),
  localparam int FLIT_W          = flit_w(DEST_BITS, VC_BITS, FLIT_DATA_WIDTH),
  localparam int CRED_W          = cred_w(VC_BITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [DEST_BITS-1:0] dest_cfg,
  output logic [FLIT_W-1:0]    flit_out,
  input  logic [FLIT_W-1:0]    flit_in,
  input  logic [CRED_W-1:0]    credit_in,
  output logic [CRED_W-1:0]    credit_out,
  output logic [31:0]          tx_count,
  output logic [31:0]          rx_count,
  output logic                 done,
  output logic                 err_credit
);

  localparam int FLD_VALID    = fld_valid(DEST_BITS, VC_BITS, FLIT_DATA_WIDTH);
  localparam int FLD_TAIL     = fld_tail(DEST_BITS, VC_BITS, FLIT_DATA_WIDTH);
  localparam int FLD_DEST_LSB = fld_dest_lsb(VC_BITS, FLIT_DATA_WIDTH);
  localparam int FLD_VC_LSB   = fld_vc_lsb(FLIT_DATA_WIDTH);

  localparam int PER_W  = max1($clog2(INJ_PERIOD));
  localparam int FIDX_W = max1($clog2(PKT_LEN));
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(INJ_PERIOD - 1);
  localparam logic [FIDX_W-1:0] FIDX_LAST = FIDX_W'(PKT_LEN - 1);

  pe_state_e             r_state;
  logic [PER_W-1:0]      r_period;
  logic [31:0]           r_pkt_idx;
  logic [FIDX_W-1:0]     r_flit_idx;
  logic [DEST_BITS-1:0]  r_dest;
  logic [VC_BITS-1:0]    r_vc;
  logic [FLIT_W-1:0]     r_flit_out;
  logic [CRED_W-1:0]     r_credit_out;
  logic [31:0]           r_tx;
  logic [31:0]           r_rx;
  logic                  r_done;
  logic                  r_err;

  logic [NUM_VCS-1:0]    w_avail;
  logic [NUM_VCS-1:0]    w_ovf;
  logic [NUM_VCS-1:0]    w_dec;
  logic [NUM_VCS-1:0]    w_inc;
  logic                  w_rx_valid;
  logic [VC_BITS-1:0]    w_rx_vc;
  logic                  w_cin_valid;
  logic [VC_BITS-1:0]    w_cin_vc;
  logic                  w_send;
  logic                  w_tail;
  logic                  w_attempt;
  logic                  w_last_pkt;
  logic [31:0]           w_next_pkt;
  logic [FLIT_DATA_WIDTH-1:0] w_data;
  logic                  w_unused_flit_in;

  assign w_rx_valid  = flit_in[FLD_VALID];
  assign w_rx_vc     = flit_in[FLD_VC_LSB +: VC_BITS];
  assign w_cin_valid = credit_in[CRED_W-1];
  assign w_cin_vc    = credit_in[VC_BITS-1:0];
  assign w_unused_flit_in = ^{flit_in[FLD_TAIL:FLD_DEST_LSB], flit_in[FLIT_DATA_WIDTH-1:0]};

  assign w_attempt  = (r_period == PER_LAST);
  assign w_send     = (r_state == PE_SEND) && w_avail[r_vc];
  assign w_tail     = (r_flit_idx == FIDX_LAST);
  assign w_next_pkt = r_pkt_idx + 32'd1;
  assign w_last_pkt = (NUM_PKTS != 0) && (w_next_pkt == 32'(NUM_PKTS));
  assign w_data     = FLIT_DATA_WIDTH'({r_pkt_idx, FLIT_IDX_FIELD_W'(r_flit_idx)});

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_cc
    assign w_dec[v] = w_send && (r_vc == VC_BITS'(v));
    assign w_inc[v] = w_cin_valid && (w_cin_vc == VC_BITS'(v));

    noc_credit_counter #(
      .BUF_DEPTH(BUF_DEPTH)
    ) u_cc (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .i_dec     (w_dec[v]),
      .i_inc     (w_inc[v]),
      .o_avail   (w_avail[v]),
      .o_overflow(w_ovf[v])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PE_IDLE;
      r_period     <= '0;
      r_pkt_idx    <= '0;
      r_flit_idx   <= '0;
      r_dest       <= '0;
      r_vc         <= '0;
      r_flit_out   <= '0;
      r_credit_out <= '0;
      r_tx         <= '0;
      r_rx         <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (en) begin
      // Period counter free-runs in every state; attempts outside IDLE are dropped.
      r_period     <= w_attempt ? '0 : r_period + 1'b1;
      r_flit_out   <= '0;
      r_credit_out <= w_rx_valid ? {1'b1, w_rx_vc} : '0;
      if (w_rx_valid) r_rx <= r_rx + 32'd1;
      if (|w_ovf) r_err <= 1'b1;

      case (r_state)
        PE_IDLE: begin
          if (w_attempt) begin
            r_state    <= PE_SEND;
            r_dest     <= dest_cfg;
            r_vc       <= VC_BITS'(r_pkt_idx % 32'(NUM_VCS));
            r_flit_idx <= '0;
          end
        end
        PE_SEND: begin
          if (w_send) begin
            r_flit_out <= {1'b1, w_tail, r_dest, r_vc, w_data};
            r_tx       <= r_tx + 32'd1;
            if (w_tail) begin
              r_flit_idx <= '0;
              r_pkt_idx  <= w_next_pkt;
              if (w_last_pkt) begin
                r_state <= PE_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= PE_IDLE;
              end
            end else begin
              r_flit_idx <= r_flit_idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else begin
      // Drop pending valid pulses so nothing re-appears when en returns.
      r_flit_out   <= '0;
      r_credit_out <= '0;
    end
  end

  assign flit_out   = en ? r_flit_out   : '0;
  assign credit_out = en ? r_credit_out : '0;
  assign tx_count   = en ? r_tx         : '0;
  assign rx_count   = en ? r_rx         : '0;
  assign done       = en && r_done;
  assign err_credit = en && r_err;

endmodule

// File: doc/noc_traffic_pe.md
NOC_TRAFFIC_PE -- requirements
Module: noc_traffic_pe

Interface
REQ-001 SHALL have parameter NUM_VCS, default 2, number of virtual channels (>=1).
REQ-002 SHALL have parameter FLIT_DATA_WIDTH, default 64, flit payload width.
REQ-003 SHALL have parameter NUM_RECV_PORTS, default 16, NoC endpoints; DEST_BITS = clog2(NUM_RECV_PORTS).
REQ-004 SHALL have parameter BUF_DEPTH, default 8, downstream buffer depth per VC = initial credits.
REQ-005 SHALL have parameter PKT_LEN, default 4, flits per packet (>=1).
REQ-006 SHALL have parameter INJ_PERIOD, default 10, cycles between packet-start attempts (>=1).
REQ-007 SHALL have parameter NUM_PKTS, default 13, packets to send; 0 = unlimited.
REQ-008 SHALL have derived widths: VC_BITS = max(1, clog2(NUM_VCS)); FLIT_W = 2+DEST_BITS+VC_BITS+FLIT_DATA_WIDTH; CRED_W = 1+VC_BITS.
REQ-009 clk  in  1  clock; all state on rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 en  in  1  synchronous enable; 0 freezes all state, outputs driven 0 (valid bits low).
REQ-012 dest_cfg  in  DEST_BITS  destination of generated packets; sampled at packet start.
REQ-013 flit_out  out  FLIT_W  {valid, tail, dest, vc, data}, MSB first.
REQ-014 flit_in  in  FLIT_W  received flit, same layout.
REQ-015 credit_in  in  CRED_W  {valid, vc} credit returned by router.
REQ-016 credit_out  out  CRED_W  {valid, vc} credit returned to router.
REQ-017 tx_count, rx_count  out  32 each  flits sent / received.
REQ-018 done  out  1  all NUM_PKTS packets sent; err_credit  out  1  sticky credit-overflow flag.

Function
REQ-019 Injection FSM states: IDLE, SEND, DONE; SEND is entered from IDLE on the cycle the period counter reaches INJ_PERIOD-1, the counter wrapping to 0 there and running continuously in IDLE.
REQ-020 At packet start the block SHALL latch dest_cfg and select VC = packet index mod NUM_VCS.
REQ-021 In SEND one flit SHALL be emitted per cycle iff credit[vc] > 0; otherwise flit_out valid = 0 (stall) with no state advance.
REQ-022 Flit data SHALL be {packet index (upper bits), flit index within packet (low 8 bits)} zero-extended/truncated to FLIT_DATA_WIDTH.
REQ-023 Tail bit SHALL be 1 only on flit PKT_LEN-1; after tail, FSM returns to IDLE, or DONE if packet count == NUM_PKTS (NUM_PKTS != 0).
REQ-024 DONE SHALL hold done = 1, emit nothing, and exit only by reset.
REQ-025 Period attempts arriving while in SEND SHALL be dropped (no queuing).
REQ-026 credit[v] SHALL reset to BUF_DEPTH, decrement on a send on v, increment on credit_in valid for v; both same cycle -> unchanged.
REQ-027 Increment that would exceed BUF_DEPTH SHALL saturate and set err_credit.
REQ-028 Received valid flit SHALL increment rx_count and produce credit_out = {1, flit vc} exactly one cycle later; one credit per received flit, back-to-back supported.
REQ-029 flit_out and credit_out SHALL be registered; valid lasts one cycle per flit/credit.
REQ-030 tx_count/rx_count SHALL wrap modulo 2^32.

Reset
REQ-031 Asserting rst_n low SHALL immediately clear flit_out, credit_out, tx_count, rx_count, done, err_credit, period counter, packet/flit indices, FSM to IDLE, and set all credits to BUF_DEPTH, including mid-packet (partial packet abandoned).
REQ-032 After deassertion the first packet start SHALL occur at the INJ_PERIOD-th enabled cycle.

Structure
REQ-033 Flit field offsets, width functions and FSM state encoding SHALL live in shared package noc_pe_pkg, reusable by monitor and router-side blocks.
REQ-034 Per-VC credit logic SHALL be one sub-module, noc_credit_counter, instantiated NUM_VCS times.

Verification
REQ-035 Defaults, infinite credits returned 1 cycle after each send -> packet 0 starts cycle 10, 4 flits on VC0 data 0x00..0x03, tail on 4th; packet 1 on VC1 at cycle 20.
REQ-036 BUF_DEPTH=2, no credits returned -> 2 flits sent, valid low thereafter; one credit_in on VC0 -> 3rd flit next cycle.
REQ-037 Simultaneous send and credit_in on the same VC -> credit count unchanged; extra credit at BUF_DEPTH -> err_credit = 1, count stays 8.
REQ-038 NUM_PKTS=2 -> exactly 8 flits, done = 1 after 2nd tail, tx_count = 8 stable.
REQ-039 Five back-to-back valid flits on flit_in VC1 -> five consecutive credit_out {1,1} one cycle delayed, rx_count = 5.
REQ-040 rst_n pulsed low after 2nd flit of a packet -> outputs zero at once, credits = 8, next packet at cycle 10 after release with flit index 0.
